// File: rtl/arb_2t_burst_xfer.sv
// Burst transfer stage behind the two-tier arbiter: latches the granted source as owner,
// forwards its beats combinationally and locks the arbiter until the owner's last beat.
module arb_2t_burst_xfer #(
    parameter int N         = 4,
    parameter int IDX_W     = 2,
    parameter int DATA_W    = 32,
    parameter int MAX_BEATS = 16,
    parameter int BEAT_W    = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                granted,
    input  logic [IDX_W-1:0]    grant_index,
    input  logic [N-1:0]        src_valid,
    input  logic [N*DATA_W-1:0] src_data,
    input  logic [N-1:0]        src_last,
    output logic [N-1:0]        src_ready,
    output logic [N-1:0]        lock,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_last,
    output logic [IDX_W-1:0]    out_owner,
    input  logic                out_ready,
    output logic                busy,
    output logic                err_overrun,
    input  logic                err_clr
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t              state, state_next;
    logic [IDX_W-1:0]    owner, owner_next;
    logic [BEAT_W-1:0]   beat_cnt, beat_cnt_next;
    logic                err_next;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_valid;
    logic                sel_last;
    logic                grant_ok;
    logic                beat_xfer;

    // Owner's lane is selected with a compare loop so any N works, not just powers of two.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (owner == IDX_W'(i)) begin
                sel_data  = src_data[i*DATA_W +: DATA_W];
                sel_valid = src_valid[i];
                sel_last  = src_last[i];
            end
        end
    end

    assign grant_ok  = granted && (32'(grant_index) < N);
    assign beat_xfer = (state == XFER) && sel_valid && out_ready;

    always_comb begin
        state_next    = state;
        owner_next    = owner;
        beat_cnt_next = beat_cnt;
        err_next      = err_overrun & ~err_clr;
        busy          = 1'b0;
        lock          = '0;
        src_ready     = '0;
        out_valid     = 1'b0;
        out_data      = sel_data;
        out_last      = sel_last;
        out_owner     = owner;

        case (state)
            IDLE: begin
                if (grant_ok) begin
                    owner_next    = grant_index;
                    beat_cnt_next = '0;
                    state_next    = XFER;
                end
            end
            XFER: begin
                busy             = 1'b1;
                lock[owner]      = 1'b1;
                src_ready[owner] = out_ready;
                out_valid        = sel_valid;
                if (beat_xfer) begin
                    if (sel_last) begin
                        state_next    = IDLE;
                        beat_cnt_next = '0;
                    end else begin
                        // Overrun is only flagged; the burst keeps running until its last beat.
                        if (beat_cnt == BEAT_W'(MAX_BEATS - 1))
                            err_next = 1'b1;
                        if (beat_cnt != '1)
                            beat_cnt_next = beat_cnt + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= '0;
            beat_cnt    <= '0;
            err_overrun <= 1'b0;
        end else begin
            state       <= state_next;
            owner       <= owner_next;
            beat_cnt    <= beat_cnt_next;
            err_overrun <= err_next;
        end
    end

endmodule

// File: tb/tb_arb_2t_burst_xfer.sv
// Directed bench for arb_2t_burst_xfer: per-cycle vector table plus hand sequences for
// overrun, error clear and reset during a burst.
module tb_arb_2t_burst_xfer;

    localparam int N = 4, IDX_W = 2, DATA_W = 32, MAX_BEATS = 16, BEAT_W = 5;

    logic                clk = 1'b0;
    logic                rst_n, granted, out_ready, err_clr;
    logic [IDX_W-1:0]    grant_index;
    logic [N-1:0]        src_valid, src_last, src_ready, lock;
    logic [N*DATA_W-1:0] src_data;
    logic                out_valid, out_last, busy, err_overrun;
    logic [DATA_W-1:0]   out_data;
    logic [IDX_W-1:0]    out_owner;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    arb_2t_burst_xfer #(.N(N), .IDX_W(IDX_W), .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS), .BEAT_W(BEAT_W)) dut (
        .clk(clk), .rst_n(rst_n), .granted(granted), .grant_index(grant_index),
        .src_valid(src_valid), .src_data(src_data), .src_last(src_last), .src_ready(src_ready),
        .lock(lock), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_owner(out_owner), .out_ready(out_ready), .busy(busy),
        .err_overrun(err_overrun), .err_clr(err_clr)
    );

    typedef struct {
        logic        rst;
        logic        gnt;
        logic [1:0]  gidx;
        logic [3:0]  sv;
        logic [3:0]  sl;
        logic        ordy;
        logic        clr;
        int          dsrc;
        logic [31:0] d;
        logic        ebusy;
        logic [3:0]  elock;
        logic [3:0]  esrdy;
        logic        eov;
        logic [31:0] eod;
        logic        eol;
        logic [1:0]  eown;
        logic        eerr;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, gnt, input logic [1:0] gidx, input logic [3:0] sv, sl,
                       input logic ordy, clr, input int dsrc, input logic [31:0] d,
                       input logic ebusy, input logic [3:0] elock, esrdy, input logic eov,
                       input logic [31:0] eod, input logic eol, input logic [1:0] eown,
                       input logic eerr);
        vec_t v;
        v = '{rst, gnt, gidx, sv, sl, ordy, clr, dsrc, d, ebusy, elock, esrdy, eov, eod, eol, eown, eerr};
        vq.push_back(v);
    endtask

    // Non-target sources carry a recognisable junk pattern so a wrong mux select shows up.
    task automatic drive(input logic rst, gnt, input logic [1:0] gidx, input logic [3:0] sv, sl,
                         input logic ordy, clr, input int dsrc, input logic [31:0] d);
        rst_n       = rst;
        granted     = gnt;
        grant_index = gidx;
        src_valid   = sv;
        src_last    = sl;
        out_ready   = ordy;
        err_clr     = clr;
        for (int i = 0; i < N; i++)
            src_data[i*DATA_W +: DATA_W] = (i == dsrc) ? d : (32'h5A5A_0000 | 32'(i));
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] obs(input logic mask);
        return {18'b0, busy, lock, src_ready, out_valid, mask ? 32'h0 : out_data,
                mask ? 1'b0 : out_last, out_owner, err_overrun};
    endfunction

    initial begin
        // rst gnt gidx sv sl ordy clr dsrc d | busy lock srdy ov od ol own err
        // reset with grant and all valids asserted
        add(0,1,2'd1,4'hF,4'h0,1,0,0,32'h0,       0,4'h0,4'h0,0,32'h0,0,2'd0,0);
        add(0,1,2'd1,4'hF,4'h0,1,0,0,32'h0,       0,4'h0,4'h0,0,32'h0,0,2'd0,0);
        add(0,1,2'd1,4'hF,4'h0,1,0,0,32'h0,       0,4'h0,4'h0,0,32'h0,0,2'd0,0);
        // basic burst from source 2
        add(1,1,2'd2,4'h0,4'h0,1,0,2,32'h0,       0,4'h0,4'h0,0,32'h0,0,2'd0,0);
        add(1,0,2'd0,4'h4,4'h0,1,0,2,32'hA0,      1,4'h4,4'h4,1,32'hA0,0,2'd2,0);
        add(1,0,2'd0,4'h4,4'h0,1,0,2,32'hA1,      1,4'h4,4'h4,1,32'hA1,0,2'd2,0);
        add(1,0,2'd0,4'h4,4'h4,1,0,2,32'hA2,      1,4'h4,4'h4,1,32'hA2,1,2'd2,0);
        add(1,0,2'd0,4'h4,4'h0,1,0,2,32'hA3,      0,4'h0,4'h0,0,32'h0,0,2'd2,0);
        // backpressure on source 1
        add(1,1,2'd1,4'h0,4'h0,1,0,1,32'h0,       0,4'h0,4'h0,0,32'h0,0,2'd2,0);
        add(1,0,2'd0,4'h2,4'h0,1,0,1,32'hB0,      1,4'h2,4'h2,1,32'hB0,0,2'd1,0);
        add(1,0,2'd0,4'h2,4'h2,0,0,1,32'hB1,      1,4'h2,4'h0,1,32'hB1,1,2'd1,0);
        add(1,0,2'd0,4'h2,4'h2,0,0,1,32'hB1,      1,4'h2,4'h0,1,32'hB1,1,2'd1,0);
        add(1,0,2'd0,4'h2,4'h2,1,0,1,32'hB1,      1,4'h2,4'h2,1,32'hB1,1,2'd1,0);
        add(1,0,2'd0,4'h0,4'h0,1,0,1,32'h0,       0,4'h0,4'h0,0,32'h0,0,2'd1,0);
        // grant moves to 3 while source 0 is bursting; source 3 waits
        add(1,1,2'd0,4'h0,4'h0,1,0,0,32'h0,       0,4'h0,4'h0,0,32'h0,0,2'd1,0);
        add(1,1,2'd3,4'h9,4'h8,1,0,0,32'hC0,      1,4'h1,4'h1,1,32'hC0,0,2'd0,0);
        add(1,1,2'd3,4'h9,4'h9,1,0,0,32'hC1,      1,4'h1,4'h1,1,32'hC1,1,2'd0,0);
        add(1,1,2'd3,4'h8,4'h8,1,0,3,32'hD0,      0,4'h0,4'h0,0,32'h0,0,2'd0,0);
        add(1,0,2'd0,4'h8,4'h8,1,0,3,32'hD0,      1,4'h8,4'h8,1,32'hD0,1,2'd3,0);
        add(1,0,2'd0,4'h0,4'h0,1,0,3,32'h0,       0,4'h0,4'h0,0,32'h0,0,2'd3,0);

        drive(0, 1, 2'd1, 4'hF, 4'h0, 1, 0, 0, 32'h0);
        @(posedge clk);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i].rst, vq[i].gnt, vq[i].gidx, vq[i].sv, vq[i].sl,
                  vq[i].ordy, vq[i].clr, vq[i].dsrc, vq[i].d);
            #1;
            chk($sformatf("vec%0d", i), obs(!vq[i].eov),
                {18'b0, vq[i].ebusy, vq[i].elock, vq[i].esrdy, vq[i].eov,
                 vq[i].eov ? vq[i].eod : 32'h0, vq[i].eov ? vq[i].eol : 1'b0,
                 vq[i].eown, vq[i].eerr});
        end

        // 17-beat burst from source 0; err_clr on the 16th beat loses to the overrun set
        @(negedge clk);
        drive(1, 1, 2'd0, 4'h0, 4'h0, 1, 0, 0, 32'h0);
        for (int b = 0; b < 17; b++) begin
            @(negedge clk);
            drive(1, 0, 2'd0, 4'h1, (b == 16) ? 4'h1 : 4'h0, 1, (b == 15), 0, 32'hE000_0000 + 32'(b));
            #1;
            chk($sformatf("ovr_data%0d", b), {out_valid, busy, lock, out_data},
                {1'b1, 1'b1, 4'h1, 32'hE000_0000 + 32'(b)});
            chk($sformatf("ovr_err%0d", b), err_overrun, (b >= 16));
        end
        @(negedge clk);
        drive(1, 0, 2'd0, 4'h0, 4'h0, 1, 0, 0, 32'h0);
        #1;
        chk("ovr_done", {busy, lock, err_overrun}, {1'b0, 4'h0, 1'b1});
        @(negedge clk);
        drive(1, 0, 2'd0, 4'h0, 4'h0, 1, 1, 0, 32'h0);
        @(negedge clk);
        drive(1, 0, 2'd0, 4'h0, 4'h0, 1, 0, 0, 32'h0);
        #1;
        chk("err_clr", err_overrun, 1'b0);

        // reset after 2 of 5 beats from source 2
        @(negedge clk);
        drive(1, 1, 2'd2, 4'h0, 4'h0, 1, 0, 2, 32'h0);
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            drive(1, 0, 2'd0, 4'h4, 4'h0, 1, 0, 2, 32'hF0 + 32'(b));
            #1;
            chk($sformatf("rmb_beat%0d", b), {busy, lock, src_ready, out_data},
                {1'b1, 4'h4, 4'h4, 32'hF0 + 32'(b)});
        end
        @(negedge clk);
        drive(0, 0, 2'd0, 4'h4, 4'h0, 1, 0, 2, 32'hF2);
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            drive(1, 0, 2'd0, 4'h4, (b == 2) ? 4'h4 : 4'h0, 1, 0, 2, 32'hF2 + 32'(b));
            #1;
            chk($sformatf("rmb_idle%0d", b), {busy, lock, src_ready, out_valid, out_owner},
                {1'b0, 4'h0, 4'h0, 1'b0, 2'd0});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/arb_2t_burst_xfer.md
Name: arb_2t_burst_xfer

Overview:
- Downstream consumer of the two-tier arbiter.
- Takes the arbiter's registered grant (granted, grant_index), latches the winning requester as burst owner, and routes that source's valid/ready data beats to a single output port until the source marks its last beat.
- Drives a per-source lock vector back to the arbiter's lock input, so ownership cannot change mid-burst.
- Tracks beat count and flags bursts that exceed a programmed maximum.

Parameters:
- N, 4: number of requesters; matches arbiter n.
- IDX_W, 2: grant_index width, ceil(log2(N)).
- DATA_W, 32: payload width per source.
- MAX_BEATS, 16: burst length limit before overrun flag; must be >= 1.
- BEAT_W, 5: beat counter width; must satisfy 2^BEAT_W > MAX_BEATS.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- granted  in  1  arbiter granted flag.
- grant_index  in  IDX_W  arbiter grant index.
- src_valid  in  N  per-source beat valid.
- src_data  in  N*DATA_W  per-source payload; source i occupies bits [i*DATA_W +: DATA_W].
- src_last  in  N  per-source last-beat marker, qualified by src_valid.
- src_ready  out  N  per-source beat accept.
- lock  out  N  to arbiter lock input; one-hot on owner while busy.
- out_valid  out  1  output beat valid.
- out_data  out  DATA_W  output payload.
- out_last  out  1  output last-beat marker.
- out_owner  out  IDX_W  index of current owner.
- out_ready  in  1  downstream accept.
- busy  out  1  high in XFER state.
- err_overrun  out  1  sticky: a burst exceeded MAX_BEATS.
- err_clr  in  1  clears err_overrun.

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE, owner=0, beat_cnt=0, err_overrun=0. Consequently busy=0, lock=0, src_ready=0, out_valid=0, out_owner=0. out_data and out_last are don't-care while out_valid=0. Reset mid-burst abandons the burst; no further beats are accepted.
- FSM has two states, IDLE and XFER.
- IDLE: if granted=1 and grant_index<N, then on the next edge owner<=grant_index, beat_cnt<=0, state<=XFER. grant_index>=N is ignored and the block stays in IDLE. No beats move in IDLE.
- XFER:
  - busy=1; lock[owner]=1, all other lock bits 0.
  - out_valid=src_valid[owner]; out_data=src_data[owner]; out_last=src_last[owner]; out_owner=owner.
  - src_ready[owner]=out_ready; all other src_ready bits 0.
  - Paths from source to output are combinational: zero-cycle latency, no buffering.
- Beat handshake: a beat transfers when src_valid[owner] and out_ready are both high at a rising edge; beat_cnt then increments.
- Last beat: a transfer with src_last[owner]=1 moves state to IDLE on the same edge and clears beat_cnt.
  - lock drops one cycle after the last beat.
  - The arbiter may re-grant from the next cycle.
  - The earliest new XFER begins 2 cycles after the last beat edge (one IDLE cycle).
- Grant inputs are ignored while in XFER, including grant changes and granted=0.
- Overrun: a transfer that occurs with beat_cnt==MAX_BEATS-1 and src_last=0 sets err_overrun. The burst continues and is never force-terminated. beat_cnt saturates at 2^BEAT_W-1.
- err_clr=1 clears err_overrun on the next edge. If a set event occurs in the same cycle, set wins.
- Backpressure: out_ready=0 holds the beat; src_ready stays 0. Sources must hold data and last stable while valid.
- src_valid and src_last from non-owners have no effect.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with granted=1 and src_valid=4'hF -> busy=0, lock=0, src_ready=0, out_valid=0, err_overrun=0.
- Basic burst:
  - Stimulus: granted=1, grant_index=2; source 2 sends 3 beats with data 0xA0, 0xA1, 0xA2 (last on the third); out_ready=1.
  - Required response: lock=4'b0100 from the cycle after the grant; out_data in order 0xA0, 0xA1, 0xA2; out_owner=2; lock=0 the cycle after the last beat.
- Backpressure: out_ready toggles 1,0,0,1 during source 1's 2-beat burst -> exactly 2 transfers; data held stable while stalled; src_ready[1] mirrors out_ready.
- Grant change mid-burst: grant_index switches 0->3 during source 0's burst -> owner stays 0; source 3 sees src_ready[3]=0 until source 0 completes its last beat and a new grant is taken.
- Overrun:
  - Stimulus: MAX_BEATS=16; source 0 sends 17 beats with last on the 17th.
  - Required response: err_overrun rises after the 16th beat; the burst completes normally.
  - Then assert err_clr for 1 cycle -> err_overrun=0.
- Reset mid-burst: rst_n=0 after 2 of 5 beats -> next cycle busy=0, lock=0; the remaining beats are not accepted.
